// File: rtl/xsimbus_arbiter_pkg.sv
// rtl/xsimbus_arbiter_pkg.sv - shared xSimBus arbiter defines
package xsimbus_arbiter_pkg;

    localparam int XSimBusMasterNum   = 4;
    localparam int XSimBusMasterIdBus = 5;
    localparam int XSimBusIdleId      = 31;
    localparam int XSimBusMaxHold     = 16;

    localparam logic HoldEnable  = 1'b1;
    localparam logic HoldDisable = 1'b0;
    localparam logic RstEnable   = 1'b1;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ArbIdle = 2'd0;
    localparam arb_state_t ArbBusy = 2'd1;
    localparam arb_state_t ArbGap  = 2'd2;

endpackage

// File: rtl/xsimbus_arbiter_if.sv
// rtl/xsimbus_arbiter_if.sv - request/grant bundle between masters and the arbiter
interface xsimbus_arbiter_if
    import xsimbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = XSimBusMasterNum,
    parameter int ID_W        = XSimBusMasterIdBus
);
    logic [NUM_MASTERS-1:0] req_in;
    logic                   done_in;
    logic [NUM_MASTERS-1:0] grant_out;
    logic [ID_W-1:0]        master_id_out;
    logic                   hold_flag_out;
    logic                   timeout_out;

    modport slave (
        input  req_in, done_in,
        output grant_out, master_id_out, hold_flag_out, timeout_out
    );

    modport master (
        output req_in, done_in,
        input  grant_out, master_id_out, hold_flag_out, timeout_out
    );
endinterface

// File: rtl/xsimbus_arbiter_rr_pick.sv
// rtl/xsimbus_arbiter_rr_pick.sv - rotate-priority select starting at rr_ptr
module xsimbus_arbiter_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int PTR_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [PTR_W-1:0]       rr_ptr,
    output logic [PTR_W-1:0]       sel,
    output logic                   valid
);
    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        sel   = '0;
        valid = |req;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % NUM_MASTERS]) begin
                sel = PTR_W'((int'(rr_ptr) + i) % NUM_MASTERS);
            end
        end
    end
endmodule

// File: rtl/xsimbus_arbiter.sv
// rtl/xsimbus_arbiter.sv - registered round-robin arbiter with watchdog for xSimBus
module xsimbus_arbiter
    import xsimbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = XSimBusMasterNum,
    parameter int ID_W        = XSimBusMasterIdBus,
    parameter int IDLE_ID     = XSimBusIdleId,
    parameter int MAX_HOLD    = XSimBusMaxHold
) (
    input  logic            clk,
    input  logic            rst,
    xsimbus_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(MAX_HOLD);

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cur_idx;
    logic [CNT_W-1:0] hold_cnt;
    logic [PTR_W-1:0] pick_sel;
    logic             pick_valid;
    logic             watchdog_hit;
    logic             release_now;

    xsimbus_arbiter_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .PTR_W      (PTR_W)
    ) u_rr_pick (
        .req   (bus.req_in),
        .rr_ptr(rr_ptr),
        .sel   (pick_sel),
        .valid (pick_valid)
    );

    assign watchdog_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now  = bus.done_in || !bus.req_in[cur_idx] || watchdog_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state             <= ArbIdle;
            rr_ptr            <= '0;
            cur_idx           <= '0;
            hold_cnt          <= '0;
            bus.grant_out     <= '0;
            bus.master_id_out <= ID_W'(IDLE_ID);
            bus.hold_flag_out <= HoldDisable;
            bus.timeout_out   <= 1'b0;
        end else begin
            bus.timeout_out <= 1'b0;
            case (state)
                ArbIdle: begin
                    if (pick_valid) begin
                        state             <= ArbBusy;
                        cur_idx           <= pick_sel;
                        hold_cnt          <= '0;
                        bus.grant_out     <= NUM_MASTERS'(1) << pick_sel;
                        bus.master_id_out <= ID_W'(pick_sel);
                        bus.hold_flag_out <= HoldEnable;
                        rr_ptr            <= (pick_sel == PTR_W'(NUM_MASTERS - 1)) ? '0 : pick_sel + 1'b1;
                    end
                end
                ArbBusy: begin
                    if (release_now) begin
                        state             <= ArbGap;
                        bus.grant_out     <= '0;
                        bus.master_id_out <= ID_W'(IDLE_ID);
                        bus.hold_flag_out <= HoldDisable;
                        // A completing transaction is never reported as a timeout.
                        bus.timeout_out   <= watchdog_hit && !bus.done_in;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ArbIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_xsimbus_arbiter.sv
// tb/tb_xsimbus_arbiter.sv - directed self-checking bench for xsimbus_arbiter
module tb_xsimbus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    xsimbus_arbiter_if #(.NUM_MASTERS(4), .ID_W(5)) bus ();

    xsimbus_arbiter #(
        .NUM_MASTERS(4),
        .ID_W       (5),
        .IDLE_ID    (31),
        .MAX_HOLD   (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant_out), 32'h0);
        chk({tag, "_id"}, 32'(bus.master_id_out), 32'd31);
        chk({tag, "_hold"}, 32'(bus.hold_flag_out), 32'h0);
    endtask

    task automatic expect_grant(input string tag, input int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        chk({tag, "_grant"}, 32'(bus.grant_out), 32'(oh));
        chk({tag, "_id"}, 32'(bus.master_id_out), 32'(idx));
        chk({tag, "_hold"}, 32'(bus.hold_flag_out), 32'h1);
    endtask

    initial begin
        bus.req_in  = 4'b0000;
        bus.done_in = 1'b0;
        step();
        step();
        expect_idle("reset");
        chk("reset_timeout", 32'(bus.timeout_out), 32'h0);
        rst = 1'b0;

        // Single request, completion via done_in, re-grant after the gap.
        bus.req_in = 4'b0100;
        step();
        expect_grant("single", 2);
        step();
        step();
        expect_grant("single_hold", 2);
        bus.done_in = 1'b1;
        step();
        expect_idle("single_rel");
        chk("single_rel_to", 32'(bus.timeout_out), 32'h0);
        bus.done_in = 1'b0;
        step();
        expect_idle("single_gap");
        step();
        expect_grant("single_regrant", 2);

        // Withdrawal releases without a timeout.
        bus.req_in = 4'b0000;
        step();
        expect_idle("withdraw_rel");
        chk("withdraw_to", 32'(bus.timeout_out), 32'h0);
        step();

        // Async reset mid-BUSY clears outputs and the round-robin pointer.
        bus.req_in = 4'b0100;
        step();
        expect_grant("pre_reset", 2);
        rst = 1'b1;
        #1;
        expect_idle("async_reset");
        step();
        rst = 1'b0;
        bus.req_in = 4'b1001;
        step();
        expect_grant("post_reset", 0);
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        step();

        // Round-robin order with all masters requesting.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_grant("rr", k % 4);
            bus.done_in = 1'b1;
            step();
            expect_idle("rr_rel");
            bus.done_in = 1'b0;
            step();
            expect_idle("rr_gap");
        end

        // Pointer wrap: grant 2 moves the pointer to 3, then 3 then 0.
        bus.req_in = 4'b0100;
        step();
        expect_grant("wrap_pre", 2);
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        step();
        bus.req_in = 4'b1001;
        step();
        expect_grant("wrap_3", 3);
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        step();
        step();
        expect_grant("wrap_0", 0);
        bus.done_in = 1'b1;
        step();
        bus.done_in = 1'b0;
        step();

        // Watchdog: 16 cycles of grant, then forced release with a timeout pulse.
        bus.req_in = 4'b0010;
        step();
        expect_grant("wd_start", 1);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("wd_held", 32'(bus.grant_out), 32'h2);
            chk("wd_no_to", 32'(bus.timeout_out), 32'h0);
        end
        step();
        expect_idle("wd_rel");
        chk("wd_timeout", 32'(bus.timeout_out), 32'h1);
        step();
        chk("wd_pulse_end", 32'(bus.timeout_out), 32'h0);
        expect_idle("wd_gap");
        step();
        expect_grant("wd_regrant", 1);

        bus.req_in = 4'b0000;
        step();
        expect_idle("wd_withdraw");
        chk("wd_withdraw_to", 32'(bus.timeout_out), 32'h0);
        step();

        // done_in on the watchdog cycle: normal release, no timeout.
        bus.req_in = 4'b0010;
        step();
        expect_grant("col_start", 1);
        for (int k = 0; k < 15; k++) begin
            step();
        end
        chk("col_last_held", 32'(bus.grant_out), 32'h2);
        bus.done_in = 1'b1;
        step();
        expect_idle("col_rel");
        chk("col_timeout", 32'(bus.timeout_out), 32'h0);
        bus.done_in = 1'b0;
        bus.req_in  = 4'b0000;
        step();
        chk("col_after", 32'(bus.timeout_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xsimbus_arbiter.md
Name: xsimbus_arbiter

Overview:
- Round-robin bus arbiter that sequences ownership of the simulation bus (xSimBus) between up to NUM_MASTERS requesting masters.
- Replaces the purely combinational priority encoder in front of the bus: grants are registered and held for a whole transaction, with fairness and a watchdog.
- Drives the master id and hold flag consumed by the bus; idle id is IDLE_ID (31), matching the bus's "no master" encoding.

Parameters:
- NUM_MASTERS, 4, number of requesters (2..31).
- ID_W, 5, width of master id output.
- IDLE_ID, 31, master id driven when no grant is active.
- MAX_HOLD, 16, maximum BUSY cycles per grant before forced release (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  NUM_MASTERS  per-master request, bit i = master i; level, held until served.
- done_in  input  1  current transaction complete; sampled only in BUSY.
- grant_out  output  NUM_MASTERS  one-hot grant, all-zero when idle.
- master_id_out  output  ID_W  index of granted master, IDLE_ID when none.
- hold_flag_out  output  1  1 while a grant is active (HoldEnable), else 0.
- timeout_out  output  1  one-cycle pulse on watchdog-forced release.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, grant_out=0, master_id_out=IDLE_ID, hold_flag_out=0, timeout_out=0.
  - rr_ptr=0, hold_cnt=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If req_in==0, stay.
  - Else select the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_MASTERS-1, 0, ...).
  - Next cycle: grant_out=onehot(sel), master_id_out=sel, hold_flag_out=1, state=BUSY, hold_cnt=0.
  - rr_ptr=(sel+1) mod NUM_MASTERS.
  - Latency: request seen at edge t, grant visible after edge t+1.
- BUSY, release conditions (evaluated each cycle):
  - a) done_in=1.
  - b) req_in[granted]=0 (master withdrew).
  - c) hold_cnt==MAX_HOLD-1. This condition also asserts timeout_out=1 for exactly one cycle, coincident with the release.
- BUSY, on any release condition: next cycle grant_out=0, master_id_out=IDLE_ID, hold_flag_out=0, state=GAP.
- BUSY, otherwise: hold_cnt increments and grant is unchanged.
- Simultaneous done_in and timeout: treated as a normal release; timeout_out=0 (done has priority).
- Requests from non-granted masters during BUSY are ignored; they are not latched and must stay asserted.
- GAP: exactly one turnaround cycle with no grant, then state=IDLE.
  - Back-to-back grants are therefore spaced by at least 2 idle-grant cycles after the release edge.
  - This guarantees the bus registers flush the previous master's data.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 other grants.
- rr_ptr wrap: (NUM_MASTERS-1)+1 -> 0.
- Invariant: grant_out is always one-hot or zero, and master_id_out==IDLE_ID iff grant_out==0.
- hold_cnt width = clog2(MAX_HOLD); it never wraps (reset on each grant).

Decomposition:
- Shared defines header gains:
  - XSimBusMasterNum.
  - XSimBusMasterIdBus.
  - XSimBusIdleId (31).
  - XSimBusMaxHold.
  - State encodings ArbIdle/ArbBusy/ArbGap.
- Reuse existing HoldEnable/HoldDisable and RstEnable.
- One sub-module: rr_pick. Combinational rotate-priority select taking req and rr_ptr, returning sel index and a valid bit.

Test Plan:
- Reset mid-BUSY: grant master 2, assert rst for 1 cycle -> immediately grant_out=0, master_id_out=31, hold_flag_out=0; after release, req_in=4'b0001 grants master 0 (rr_ptr reset).
- Single request: req_in=4'b0100 at edge 0, done_in at edge 3 -> grant_out=4'b0100, master_id_out=2 from edge 1; released at edge 4; GAP at edge 5; re-grant master 2 at edge 6 if still requesting.
- Round-robin: req_in=4'b1111 held, done_in pulsed each grant -> grant order 0,1,2,3,0; each grant separated by a 2-cycle gap.
- Wrap: rr_ptr=3, req_in=4'b1001 -> master 3 granted; next arbitration grants master 0.
- Watchdog: req_in=4'b0010, done_in=0 forever, MAX_HOLD=16 -> grant lasts 16 cycles, timeout_out pulses once at release, re-grant master 1 after GAP.
- Withdraw and collision: master 1 granted and drops req -> release next edge, timeout_out=0; separate case with done_in=1 on the watchdog cycle -> release with timeout_out=0.
